seven_segment_scan_controller: RTL and testbench
================================================

# seven_segment_scan_controller

Time-multiplexed scan controller for the board's multi-digit common-anode seven-segment display. It shares a single `seven_segment_display` hex decoder across `NUM_DIGITS` digits. It cycles anode enables at a prescaled refresh rate and inserts a blanking guard at each digit change to suppress ghosting. It snapshots the counter value once per frame so a digit never tears mid-scan. It sits between the counter core and the board pins.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; must be ≥2.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot.
- `GUARD_CYCLES`, default 2: cycles at the start of each slot with all anodes off; 1 ≤ `GUARD_CYCLES` < `REFRESH_DIV`.
- `clk`, in, 1: system clock; everything is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: scan enable; low freezes the scan and blanks the display.
- `value`, in, 4*NUM_DIGITS: hex digits; nibble i goes to digit i; digit 0 is rightmost.
- `dp_in`, in, NUM_DIGITS: decimal point request per digit, active-high.
- `an`, out, NUM_DIGITS: anode enables, active-low, registered.
- `seg`, out, 7: segments {g..a}, active-low, registered.
- `dp`, out, 1: decimal point, active-low, registered.
- `frame_done`, out, 1: one-cycle pulse on the first cycle of each new frame.

## Operation
- State:
  - prescaler `pcnt` counts 0..REFRESH_DIV-1.
  - digit index `idx` counts 0..NUM_DIGITS-1.
  - `snap` holds a registered copy of `value`.
- Advance: when `enable` is high, `pcnt` increments every cycle.
  - At `pcnt==REFRESH_DIV-1`, `pcnt` goes to 0 and `idx` increments.
  - `idx` wraps from NUM_DIGITS-1 to 0.
- Snapshot: `snap` loads `value` on every cycle with `pcnt==0 && idx==0 && enable`. This includes the first enabled cycle after reset. `snap` is otherwise held.
- Decode path:
  - `snap[4*idx +: 4]` feeds the single decoder instance.
  - The `dp` source is `dp_in[idx]`, sampled live.
- Guard: while `pcnt < GUARD_CYCLES`, next `an` is all ones and next `seg`/`dp` is blank (7'h7F / 1).
- Active slot: while `pcnt ≥ GUARD_CYCLES`:
  - next `an` has only bit `idx` low.
  - next `seg` is the decoder output.
  - next `dp` is `~dp_in[idx]`.
- `frame_done`: registered; high for one cycle following each `idx` wrap, coinciding with the snapshot load cycle. It is not asserted for the first frame after reset.
- `enable` low: `pcnt`, `idx` and `snap` hold. Next `an` is all ones and `seg`/`dp` are blank. On re-enable, the scan resumes from the held `pcnt`/`idx`; the guard is not re-applied.
- Reset mid-frame:
  - next cycle gives all outputs at reset values.
  - `pcnt`, `idx` and `snap` are cleared.
  - the scan restarts at digit 0 after release.

## Timing
- Reset values: `an`=all ones, `seg`=7'h7F, `dp`=1, `frame_done`=0, `pcnt`=0, `idx`=0, `snap`=0.
- Latency: one cycle from `pcnt`/`idx` state to pins. A slot occupies pin cycles [GUARD_CYCLES+1, REFRESH_DIV] relative to its `pcnt==0` cycle.
- Frame period: NUM_DIGITS*REFRESH_DIV enabled cycles.
- Decoder patterns are fixed: 0→7'b1000000, 4→7'b0011001, 5→7'b0010010, A→7'b0001000, F→7'b0001110.

## Configuration
- `SEVSEG_LZ_BLANK_EN`:
  - Defined: leading-zero blanking is enabled. Digit i>0 is suppressed when `snap` nibbles i..NUM_DIGITS-1 are all zero and none of `dp_in[NUM_DIGITS-1:i]` is set. A suppressed digit keeps `an` all ones and `seg` at 7'h7F for its whole slot; slot timing is unchanged. Digit 0 is never suppressed.
  - Undefined: all digits are always lit.

## Structure
- Package `seven_seg_pkg`:
  - `SEG_BLANK` = 7'h7F.
  - active-low polarity constants.
  - the `idx` width function (clog2 of NUM_DIGITS).
- One sub-module: the `seven_segment_display` decoder, instantiated exactly once as the shared resource. The rest is flat: counters, snapshot register, blank logic and output registers.

## Test plan
The bench uses NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, and cycle 0 = first cycle with `reset` low and `enable` high.
- Reset held 20 cycles with `value`=16'hFFFF → `an`=4'hF, `seg`=7'h7F, `dp`=1, `frame_done`=0 throughout.
- `value`=16'h1234, `dp_in`=0:
  - `an`=4'b1110 with `seg`=7'b0011001 on cycles 3–8.
  - `an`=4'hF on cycles 9–10.
  - `an`=4'b1101 with `seg`=7'b0110000 on cycles 11–16.
  - `frame_done` high only on cycle 32.
- `value` changes 16'h1234→16'hABCD at cycle 12 → digits 1–3 of frame 0 still show 3, 2, 1. Frame 1 (from cycle 32) shows D, C, B, A.
- With `SEVSEG_LZ_BLANK_EN` and `value`=16'h0050:
  - `an[3]` and `an[2]` are never low.
  - digit 1 shows 7'b0010010; digit 0 shows 7'b1000000.
  - adding `dp_in`=4'b0100 lights digit 2 with `seg`=7'b1000000 and `dp`=0.
  - Without the macro, all four anodes are pulsed.
- `enable` low on cycles 20–29 → `an`=4'hF on cycles 21–30; `idx` and `pcnt` are held. The scan resumes at the same digit and `frame_done` moves to cycle 42.
- `reset` pulsed high at cycle 40 → cycle 41 shows reset values. After release, digit 0 is redisplayed with a fresh snapshot of `value`.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller: blank pattern,
// active-low pin polarities and the digit-index width helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Anodes, segments and decimal point are all driven active-low.
  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  function automatic int idx_w(input int n);
    if (n > 1) return $clog2(n);
    else return 1;
  endfunction

endpackage

// File: rtl/seven_segment_display.sv
// Hex-to-seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module seven_segment_display
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed common-anode display scanner with per-slot blanking guard
// and per-frame snapshot. Define SEVSEG_LZ_BLANK_EN for leading-zero blanking.
module seven_segment_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IDX_W  = idx_w(NUM_DIGITS);
  localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [PCNT_W-1:0] GUARD_END = PCNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PCNT_W-1:0]       pcnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] snap;

  logic slot_end;
  logic frame_end;
  logic snap_load;

  assign slot_end  = (pcnt == PCNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign snap_load = enable && (pcnt == '0) && (idx == '0);

  // Stage 0: prescaler and digit index; both freeze while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (enable) begin
      if (slot_end) begin
        pcnt <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        pcnt <= pcnt + PCNT_W'(1);
      end
    end
  end

  // One copy per frame so a digit never mixes old and new counter values.
  always_ff @(posedge clk) begin
    if (reset) snap <= '0;
    else if (snap_load) snap <= value;
  end

  logic [NUM_DIGITS-1:0] lz_sup;

`ifdef SEVSEG_LZ_BLANK_EN
  logic lz_run;

  always_comb begin
    lz_sup = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run    = lz_run && (snap[4*i +: 4] == 4'h0) && !dp_in[i];
      lz_sup[i] = lz_run;
    end
  end
`else
  assign lz_sup = '0;
`endif

  logic [3:0] nib;
  logic       dp_sel;
  logic       sup_sel;
  logic [6:0] dec_seg;

  always_comb begin
    nib     = 4'h0;
    dp_sel  = 1'b0;
    sup_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib     = snap[4*i +: 4];
        dp_sel  = dp_in[i];
        sup_sel = lz_sup[i];
      end
    end
  end

  seven_segment_display u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  always_comb begin
    an_nxt  = {NUM_DIGITS{AN_OFF}};
    seg_nxt = SEG_BLANK;
    dp_nxt  = DP_OFF;
    if (enable && (pcnt >= GUARD_END) && !sup_sel) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDX_W'(i)) an_nxt[i] = AN_ON;
      end
      seg_nxt = dec_seg;
      dp_nxt  = dp_sel ? DP_ON : DP_OFF;
    end
  end

  // Stage 1: registered pins; frame_done lands on the snapshot load cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= {NUM_DIGITS{AN_OFF}};
      seg        <= SEG_BLANK;
      dp         <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= enable && frame_end;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller (4 digits, 8-cycle slots, 2-cycle guard).
module tb_seven_segment_scan_controller;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seven_segment_scan_controller #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value      (value),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at the middle of cycle 0 (reset just released).
  task automatic start_scan(input logic [15:0] v, input logic [3:0] d);
    reset  = 1'b1;
    enable = 1'b1;
    value  = v;
    dp_in  = d;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    value  = 16'hFFFF;
    dp_in  = 4'h0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset cyc=%0d an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
                 t, an, seg, dp, frame_done);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ef;
    start_scan(16'h1234, 4'h0);
    for (int t = 0; t <= 40; t++) begin
      ea = 4'hF; es = 7'h7F;
      if (t >= 3 && t <= 8)        begin ea = 4'b1110; es = 7'b0011001; end
      else if (t >= 11 && t <= 16) begin ea = 4'b1101; es = 7'b0110000; end
      else if (t >= 19 && t <= 24) begin ea = 4'b1011; es = 7'b0100100; end
      else if (t >= 27 && t <= 32) begin ea = 4'b0111; es = 7'b1111001; end
      else if (t >= 35 && t <= 40) begin ea = 4'b1110; es = 7'b0011001; end
      ef = (t == 32);
      checks++;
      if ({an, seg, dp, frame_done} !== {ea, es, 1'b1, ef}) begin
        errors++;
        $display("FAIL scan cyc=%0d an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=1 fd=%b",
                 t, an, seg, dp, frame_done, ea, es, ef);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_snapshot();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ef;
    start_scan(16'h1234, 4'h0);
    for (int t = 0; t <= 64; t++) begin
      ea = 4'hF; es = 7'h7F;
      if (t >= 3 && t <= 8)        begin ea = 4'b1110; es = 7'b0011001; end
      else if (t >= 11 && t <= 16) begin ea = 4'b1101; es = 7'b0110000; end
      else if (t >= 19 && t <= 24) begin ea = 4'b1011; es = 7'b0100100; end
      else if (t >= 27 && t <= 32) begin ea = 4'b0111; es = 7'b1111001; end
      else if (t >= 35 && t <= 40) begin ea = 4'b1110; es = 7'b0100001; end
      else if (t >= 43 && t <= 48) begin ea = 4'b1101; es = 7'b1000110; end
      else if (t >= 51 && t <= 56) begin ea = 4'b1011; es = 7'b0000011; end
      else if (t >= 59 && t <= 64) begin ea = 4'b0111; es = 7'b0001000; end
      ef = (t == 32) || (t == 64);
      checks++;
      if ({an, seg, frame_done} !== {ea, es, ef}) begin
        errors++;
        $display("FAIL snapshot cyc=%0d an=%b seg=%b fd=%b required an=%b seg=%b fd=%b",
                 t, an, seg, frame_done, ea, es, ef);
      end
      if (t == 12) value = 16'hABCD;
      @(negedge clk);
    end
  endtask

  task automatic test_enable_pause();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ef;
    start_scan(16'h1234, 4'h0);
    for (int t = 0; t <= 43; t++) begin
      ea = 4'hF; es = 7'h7F;
      if (t >= 3 && t <= 8)        begin ea = 4'b1110; es = 7'b0011001; end
      else if (t >= 11 && t <= 16) begin ea = 4'b1101; es = 7'b0110000; end
      else if (t >= 19 && t <= 20) begin ea = 4'b1011; es = 7'b0100100; end
      else if (t >= 31 && t <= 34) begin ea = 4'b1011; es = 7'b0100100; end
      else if (t >= 37 && t <= 42) begin ea = 4'b0111; es = 7'b1111001; end
      ef = (t == 42);
      checks++;
      if ({an, seg, dp, frame_done} !== {ea, es, 1'b1, ef}) begin
        errors++;
        $display("FAIL pause cyc=%0d an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=1 fd=%b",
                 t, an, seg, dp, frame_done, ea, es, ef);
      end
      if (t == 20) enable = 1'b0;
      if (t == 30) enable = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] ea;
    logic [6:0] es;
    start_scan(16'h1234, 4'h0);
    for (int t = 0; t <= 50; t++) begin
      if (t >= 41) begin
        ea = 4'hF; es = 7'h7F;
        if (t >= 44 && t <= 49) begin ea = 4'b1110; es = 7'b0001110; end
        checks++;
        if ({an, seg, dp, frame_done} !== {ea, es, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL reset_mid cyc=%0d an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=1 fd=0",
                   t, an, seg, dp, frame_done, ea, es);
        end
      end
      if (t == 40) begin reset = 1'b1; value = 16'h123F; end
      if (t == 41) reset = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_lz_blank(input logic [3:0] d);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    logic       lz;
`ifdef SEVSEG_LZ_BLANK_EN
    lz = 1'b1;
`else
    lz = 1'b0;
`endif
    start_scan(16'h0050, d);
    for (int t = 0; t <= 32; t++) begin
      ea = 4'hF; es = 7'h7F; ed = 1'b1;
      if (t >= 3 && t <= 8)        begin ea = 4'b1110; es = 7'b1000000; end
      else if (t >= 11 && t <= 16) begin ea = 4'b1101; es = 7'b0010010; end
      else if (t >= 19 && t <= 24) begin
        if (d[2]) begin ea = 4'b1011; es = 7'b1000000; ed = 1'b0; end
        else if (!lz) begin ea = 4'b1011; es = 7'b1000000; end
      end
      else if (t >= 27 && t <= 32) begin
        if (!lz) begin ea = 4'b0111; es = 7'b1000000; end
      end
      checks++;
      if ({an, seg, dp} !== {ea, es, ed}) begin
        errors++;
        $display("FAIL lz_blank dp_in=%b cyc=%0d an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                 d, t, an, seg, dp, ea, es, ed);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    value  = 16'h0;
    dp_in  = 4'h0;
    test_reset();
    test_scan();
    test_snapshot();
    test_enable_pause();
    test_reset_mid_frame();
    test_lz_blank(4'b0000);
    test_lz_blank(4'b0100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
